spi_master: RTL and testbench

//  Single-clock SPI master, one DATA_W-bit full-duplex frame per start request.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_clk_gen.sv | 65 ++++++
 rtl/spi_master.sv | 181 ++++++++++++++++++
 tb/tb_spi_master.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
//  Module   : spi_pkg
//  Desc     : Shared types, default sizes and helpers for the SPI master.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    // Frame sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_CLK_DIV = 4;

    // Conventional SPI mode number: mode = {cpol, cpha}
    function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
        return {cpol, cpha};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// ============================================================================
//  Module   : spi_clk_gen
//  Desc     : sclk generator. A divider produces one sclk edge every CLK_DIV
//             clk cycles while run is high; an edge counter limits the frame
//             to 2*DATA_W edges and flags leading/trailing/last edges.
//             While run is low, sclk parks at cpol.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_clk_gen #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic cpol,
    output logic sclk,
    output logic lead_stb,
    output logic trail_stb,
    output logic last_edge
);

    localparam int DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATA_W - 1);
    localparam logic [EDGE_W-1:0] EDGE_TOTAL = EDGE_W'(2 * DATA_W);

    logic [DIV_W-1:0]  div_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic              tick;

    // An edge is due when the divider wraps, unless the frame's edges are spent.
    // edge_cnt holds the number of edges already made, so an even count means
    // the upcoming edge is odd-numbered (leading).
    assign tick      = run && (div_cnt == DIV_LAST) && (edge_cnt != EDGE_TOTAL);
    assign lead_stb  = tick && !edge_cnt[0];
    assign trail_stb = tick &&  edge_cnt[0];
    assign last_edge = tick && (edge_cnt == EDGE_LAST);

    // Divider, edge counter and sclk toggle; all cleared/parked when not running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk     <= 1'b0;
        end else if (!run) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk     <= cpol;
        end else if (tick) begin
            div_cnt  <= '0;
            edge_cnt <= edge_cnt + EDGE_W'(1);
            sclk     <= ~sclk;
        end else if (div_cnt != DIV_LAST) begin
            div_cnt  <= div_cnt + DIV_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
//  Module   : spi_master
//  Desc     : Single-clock SPI master, one DATA_W-bit full-duplex frame per
//             accepted start. Run-time CPOL/CPHA, start/busy/done handshake.
//             Optional macro SPI_MASTER_LSB_FIRST_EN adds a lsb_first input
//             selecting LSB-first wire order per frame.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_MASTER_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic              sclk,
    output logic              ss,
    output logic              mosi,
    input  logic              miso
);

    localparam int                WAIT_W    = $clog2(CLK_DIV) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CLK_DIV - 1);

    spi_state_t        state;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              cpol_r;
    logic              cpha_r;
    logic              lsb_r;
    logic [WAIT_W-1:0] wait_cnt;

    logic              accept;
    logic              run;
    logic              cpol_gen;
    logic              lead_stb;
    logic              trail_stb;
    logic              last_edge;
    logic              sample_stb;
    logic              drive_stb;
    logic              wait_done;
    logic [1:0]        mode;
    logic              lsb_in;
    logic              lsb_sel;
    logic [DATA_W-1:0] tx_src;
    logic              tx_bit;
    logic [DATA_W-1:0] tx_next;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign lsb_in = lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // The done cycle is already IDLE; refusing start there guarantees ss stays
    // high for at least one extra clk between back-to-back frames.
    assign accept    = (state == IDLE) && start && !done;
    assign run       = (state == XFER);
    assign wait_done = (wait_cnt == WAIT_LAST);

    // Feed the new polarity on the accepting edge so sclk settles to it in the
    // same cycle ss falls, never producing a spurious edge with ss low.
    assign cpol_gen = accept ? cpol : cpol_r;

    // Modes 0 and 2 sample on the leading edge, modes 1 and 3 on the trailing one
    assign mode       = spi_mode(cpol_r, cpha_r);
    assign sample_stb = ((mode == 2'd0) || (mode == 2'd2)) ? lead_stb  : trail_stb;
    assign drive_stb  = ((mode == 2'd0) || (mode == 2'd2)) ? trail_stb : lead_stb;

    // Shared "drive next bit" path: on accept it works on data_in directly,
    // which gives cpha=0 its first bit on mosi from SETUP entry.
    assign lsb_sel = accept ? lsb_in : lsb_r;
    assign tx_src  = accept ? data_in : tx_sr;
    assign tx_bit  = lsb_sel ? tx_src[0] : tx_src[DATA_W-1];
    assign tx_next = lsb_sel ? (tx_src >> 1) : (tx_src << 1);

    spi_clk_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cpol      (cpol_gen),
        .sclk      (sclk),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .last_edge (last_edge)
    );

    // Frame sequencer: IDLE -> SETUP -> XFER -> HOLD -> IDLE, with shift registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ss       <= 1'b1;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_out <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cpol_r   <= 1'b0;
            cpha_r   <= 1'b0;
            lsb_r    <= 1'b0;
            wait_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (accept) begin
                        cpol_r   <= cpol;
                        cpha_r   <= cpha;
                        lsb_r    <= lsb_in;
                        ss       <= 1'b0;
                        busy     <= 1'b1;
                        rx_sr    <= '0;
                        wait_cnt <= '0;
                        state    <= SETUP;
                        if (cpha) begin
                            mosi  <= 1'b0;
                            tx_sr <= data_in;
                        end else begin
                            mosi  <= tx_bit;
                            tx_sr <= tx_next;
                        end
                    end
                end
                SETUP: begin
                    if (wait_done) begin
                        wait_cnt <= '0;
                        state    <= XFER;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                XFER: begin
                    if (drive_stb) begin
                        mosi  <= tx_bit;
                        tx_sr <= tx_next;
                    end
                    if (sample_stb) begin
                        rx_sr <= lsb_r ? {miso, rx_sr[DATA_W-1:1]}
                                       : {rx_sr[DATA_W-2:0], miso};
                    end
                    if (last_edge) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (wait_done) begin
                        wait_cnt <= '0;
                        ss       <= 1'b1;
                        data_out <= rx_sr;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
//  Module   : tb_spi_master
//  Desc     : Directed bench for spi_master. Two DUTs (CLK_DIV=4 and 1) share
//             one behavioural SPI slave through a selector. Macro
//             SPI_MASTER_LSB_FIRST_EN enables the LSB-first vector.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_master;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_s = 1'b0;
    logic          start_f = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          cpol = 1'b0;
    logic          cpha = 1'b0;
    logic          lsb_first = 1'b0;
    logic          miso = 1'b0;
    logic          fast = 1'b0;

    logic          busy_s, done_s, sclk_s, ss_s, mosi_s;
    logic [DW-1:0] dout_s;
    logic          busy_f, done_f, sclk_f, ss_f, mosi_f;
    logic [DW-1:0] dout_f;

    logic          busy, done, sclk, ss, mosi;
    logic [DW-1:0] dout;

    assign busy = fast ? busy_f : busy_s;
    assign done = fast ? done_f : done_s;
    assign sclk = fast ? sclk_f : sclk_s;
    assign ss   = fast ? ss_f   : ss_s;
    assign mosi = fast ? mosi_f : mosi_s;
    assign dout = fast ? dout_f : dout_s;

    always #5 clk = ~clk;

    spi_master #(.DATA_W(DW), .CLK_DIV(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .data_in   (data_in),
        .cpol      (cpol),
        .cpha      (cpha),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .busy      (busy_s),
        .done      (done_s),
        .data_out  (dout_s),
        .sclk      (sclk_s),
        .ss        (ss_s),
        .mosi      (mosi_s),
        .miso      (miso)
    );

    spi_master #(.DATA_W(DW), .CLK_DIV(1)) u_dut_fast (
        .clk       (clk),
        .rst       (rst),
        .start     (start_f),
        .data_in   (data_in),
        .cpol      (cpol),
        .cpha      (cpha),
`ifdef SPI_MASTER_LSB_FIRST_EN
        .lsb_first (lsb_first),
`endif
        .busy      (busy_f),
        .done      (done_f),
        .data_out  (dout_f),
        .sclk      (sclk_f),
        .ss        (ss_f),
        .mosi      (mosi_f),
        .miso      (miso)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    // Observes the bus on negedge clk, numbering sclk edges 1..16 while ss is low.
    logic [DW-1:0] s_tx_word = '0;
    logic [DW-1:0] s_sr = '0;
    logic [DW-1:0] s_rx = '0;
    logic          s_cpha = 1'b0;
    logic          s_lsb = 1'b0;
    logic          s_first_mosi = 1'b0;
    int            s_edges = 0;
    int            s_nsamp = 0;
    int            s_unstable = 0;
    logic          ss_q = 1'b1;
    logic          sclk_q = 1'b0;
    logic          mosi_q = 1'b0;

    task slave_drive();
        miso = s_lsb ? s_sr[0] : s_sr[DW-1];
        s_sr = s_lsb ? (s_sr >> 1) : (s_sr << 1);
    endtask

    always @(negedge clk) begin
        if (ss === 1'b0 && ss_q === 1'b1) begin
            s_sr       = s_tx_word;
            s_rx       = '0;
            s_edges    = 0;
            s_nsamp    = 0;
            s_unstable = 0;
            if (!s_cpha) slave_drive();
        end else if (ss === 1'b0 && sclk !== sclk_q) begin
            s_edges++;
            if (((s_edges % 2) == 1) == (s_cpha == 1'b0)) begin
                if (mosi !== mosi_q) s_unstable++;
                if (s_nsamp == 0) s_first_mosi = mosi;
                s_nsamp++;
                s_rx = s_lsb ? {mosi, s_rx[DW-1:1]} : {s_rx[DW-2:0], mosi};
            end else begin
                slave_drive();
            end
        end
        ss_q   = ss;
        sclk_q = sclk;
        mosi_q = mosi;
    end

    // ---------------- one frame, fully checked ----------------
    task automatic run_frame(input logic [DW-1:0] tx, input logic [DW-1:0] srx,
                             input logic p, input logic h, input logic lf,
                             input logic f, input logic poke, input string tg);
        int n;
        int lowc;
        int lat_exp;
        int extra;
        lat_exp = (2 * DW + 2) * (f ? 1 : 4) + 1;
        @(negedge clk);
        fast = f; data_in = tx; cpol = p; cpha = h; lsb_first = lf;
        s_tx_word = srx; s_cpha = h; s_lsb = lf;
        if (f) start_f = 1'b1; else start_s = 1'b1;
        @(negedge clk);
        start_f = 1'b0; start_s = 1'b0;
        n = 1; lowc = 0;
        check({tg, "_busy_first"}, busy, 1);
        check({tg, "_mosi_setup"}, mosi, h ? 1'b0 : (lf ? tx[0] : tx[DW-1]));
        while (done !== 1'b1 && n < 400) begin
            if (ss === 1'b0) lowc++;
            if (n == 2) check({tg, "_sclk_idle_pre"}, sclk, p);
            if (poke && n == 30) begin
                if (f) start_f = 1'b1; else start_s = 1'b1;
                data_in = ~tx; cpol = ~p; cpha = ~h;
            end
            if (poke && n == 31) begin start_f = 1'b0; start_s = 1'b0; end
            @(negedge clk);
            n++;
        end
        check({tg, "_latency"}, n, lat_exp);
        check({tg, "_ss_low"}, lowc, lat_exp - 1);
        check({tg, "_data_out"}, dout, srx);
        check({tg, "_slave_rx"}, s_rx, tx);
        check({tg, "_mosi_stable"}, s_unstable, 0);
        check({tg, "_sclk_idle_post"}, sclk, p);
        check({tg, "_busy_in_done"}, busy, 1);
        check({tg, "_ss_in_done"}, ss, 1);
        @(negedge clk);
        check({tg, "_done_pulse"}, done, 0);
        check({tg, "_busy_after"}, busy, 0);
        if (poke) begin
            extra = 0;
            repeat (100) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check({tg, "_no_queued_frame"}, extra, 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int t;
        int gap;
        int extra;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ss", ss, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data_out", dout, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Mode 0 reference frame
        run_frame(8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "m0");
        // Modes 1, 2, 3
        run_frame(8'h81, 8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "m1");
        run_frame(8'h81, 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "m2");
        run_frame(8'h81, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "m3");
        // start, data_in, cpol, cpha all disturbed mid-XFER
        run_frame(8'h3B, 8'hD4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "poke");

        // start held high: two back-to-back frames
        @(negedge clk);
        fast = 1'b0; data_in = 8'h5A; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        s_tx_word = 8'hC3; s_cpha = 1'b0; s_lsb = 1'b0;
        start_s = 1'b1;
        k = 0;
        while (done !== 1'b1 && k < 400) begin @(negedge clk); k++; end
        check("b2b_first_done", done, 1);
        check("b2b_first_data", dout, 8'hC3);
        gap = 1;
        @(negedge clk);
        t = 1;
        while (ss === 1'b1 && t < 20) begin gap++; @(negedge clk); t++; end
        start_s = 1'b0;
        check("b2b_gap_ge1", (gap >= 1) ? 1 : 0, 1);
        while (done !== 1'b1 && t < 400) begin @(negedge clk); t++; end
        check("b2b_second_spacing", t, 74);
        check("b2b_second_data", dout, 8'hC3);
        check("b2b_second_slave_rx", s_rx, 8'h5A);
        repeat (3) @(negedge clk);

        // Reset on edge 7 of a mode-0 frame
        @(negedge clk);
        fast = 1'b0; data_in = 8'hF0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
        s_tx_word = 8'h0F; s_cpha = 1'b0; s_lsb = 1'b0;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        #1;
        k = 0;
        while (s_edges < 7 && k < 400) begin @(negedge clk); #1; k++; end
        check("rstmid_edge7", s_edges, 7);
        check("rstmid_sclk_before", sclk, 1);
        rst = 1'b1;
        #1;
        check("rstmid_ss", ss, 1);
        check("rstmid_sclk", sclk, 0);
        check("rstmid_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("rstmid_no_done", extra, 0);
        check("rstmid_data_out", dout, 0);
        run_frame(8'h96, 8'h69, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

        // CLK_DIV = 1 instance
        run_frame(8'hC5, 8'h2B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "fast");

`ifdef SPI_MASTER_LSB_FIRST_EN
        // LSB-first: wire bits 1,0,0,0,0,0,0,0 in both directions
        run_frame(8'h01, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "lsb");
        check("lsb_first_wire_bit", s_first_mosi, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
